deglitch_ctrl: RTL and testbench

//  Clocked controller for one analog deglitch macro (set-bar latch + delay-chain feedback) on an I2C pad input.

---
 rtl/deglitch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_deglitch_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/deglitch_ctrl.sv
// deglitch_ctrl: calibrates the chain delay of one analog deglitch macro and selects
// analog, digital or bypass filtering of an I2C pad line; filt_out feeds the I2C core.
module deglitch_ctrl #(
    parameter int CNT_W    = 8,
    parameter int CAL_MAX  = 255,
    parameter int MIN_DLY  = 4,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             pad_in,
    input  logic             cal_start,
    input  logic             byp_req,
    input  logic             dg_out,
    input  logic             dg_dout,
    output logic             dg_in,
    output logic             dg_sb,
    output logic             dg_byp,
    output logic             filt_out,
    output logic [1:0]       mode,
    output logic             cal_busy,
    output logic             cal_done,
    output logic             cal_fail,
    output logic [CNT_W-1:0] cal_dly,
    output logic [2:0]       dbg_state
);

    localparam int FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [1:0] MODE_ANA = 2'd0;
    localparam logic [1:0] MODE_DIG = 2'd1;
    localparam logic [1:0] MODE_BYP = 2'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CAL_INIT  = 3'd1,
        CAL_ARM   = 3'd2,
        CAL_PULSE = 3'd3,
        CAL_EVAL  = 3'd4
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [FCNT_W-1:0] fcnt;
    logic              stim;
    logic              out_s1, out_s2;
    logic              dout_s1, dout_s2;
    logic [1:0]        sel_mode;

    assign dbg_state = state;
    // Outside calibration the macro simply sees the pad; during calibration it sees our stimulus.
    assign dg_in = (state == IDLE) ? pad_in : stim;

    always_comb begin
        sel_mode = MODE_DIG;
        if (byp_req)
            sel_mode = MODE_BYP;
        else if (cal_done && (cal_dly >= CNT_W'(MIN_DLY)))
            sel_mode = MODE_ANA;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state    <= IDLE;
            cnt      <= '0;
            fcnt     <= '0;
            stim     <= 1'b1;
            dg_sb    <= 1'b1;
            dg_byp   <= 1'b1;
            filt_out <= 1'b1;
            mode     <= MODE_DIG;
            cal_busy <= 1'b0;
            cal_done <= 1'b0;
            cal_fail <= 1'b0;
            cal_dly  <= '0;
            out_s1   <= 1'b1;
            out_s2   <= 1'b1;
            dout_s1  <= 1'b1;
            dout_s2  <= 1'b1;
        end else begin
            out_s1  <= dg_out;
            out_s2  <= out_s1;
            dout_s1 <= dg_dout;
            dout_s2 <= dout_s1;
            unique case (state)
                IDLE: begin
                    if (mode == MODE_DIG) begin
                        if (out_s2 == filt_out) begin
                            fcnt <= '0;
                        end else if (fcnt == FCNT_W'(FILT_LEN - 1)) begin
                            filt_out <= out_s2;
                            fcnt     <= '0;
                        end else begin
                            fcnt <= fcnt + FCNT_W'(1);
                        end
                    end else begin
                        filt_out <= out_s2;
                        fcnt     <= '0;
                    end
                    // Mode is frozen from calibration start until evaluation.
                    if (cal_start) begin
                        state    <= CAL_INIT;
                        cnt      <= '0;
                        cal_busy <= 1'b1;
                        cal_done <= 1'b0;
                        cal_fail <= 1'b0;
                        stim     <= 1'b1;
                        dg_sb    <= 1'b0;
                        dg_byp   <= 1'b1;
                    end else begin
                        mode   <= sel_mode;
                        dg_byp <= (sel_mode != MODE_ANA);
                    end
                end
                CAL_INIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= CAL_ARM;
                        cnt   <= '0;
                        dg_sb <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CAL_ARM: begin
                    if (dout_s2) begin
                        state <= CAL_PULSE;
                        cnt   <= '0;
                        stim  <= 1'b0;
                    end else if (cnt == CNT_W'(CAL_MAX)) begin
                        state    <= CAL_EVAL;
                        cal_fail <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CAL_PULSE: begin
                    // Two cycles of the count are the DOUT synchroniser, not the chain.
                    if (!dout_s2) begin
                        state    <= CAL_EVAL;
                        stim     <= 1'b1;
                        cal_done <= 1'b1;
                        cal_dly  <= (cnt >= CNT_W'(2)) ? cnt - CNT_W'(2) : '0;
                    end else if (cnt == CNT_W'(CAL_MAX)) begin
                        state    <= CAL_EVAL;
                        stim     <= 1'b1;
                        cal_fail <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CAL_EVAL: begin
                    state    <= IDLE;
                    cal_busy <= 1'b0;
                    dg_sb    <= 1'b1;
                    mode     <= sel_mode;
                    dg_byp   <= (sel_mode != MODE_ANA);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deglitch_ctrl.sv
// tb_deglitch_ctrl: directed and random checks of deglitch_ctrl against a delayed-macro
// model and a sample-queue model of the synchroniser and digital filter.
`timescale 1ns/1ps
module tb_deglitch_ctrl;

    localparam int CNT_W    = 8;
    localparam int CAL_MAX  = 255;
    localparam int MIN_DLY  = 4;
    localparam int FILT_LEN = 3;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PULSE = 3'd3;

    // clock / reset and DUT
    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic pad_in = 1'b1;
    logic cal_start = 1'b0;
    logic byp_req = 1'b0;
    logic dg_out = 1'b1;
    logic dg_dout = 1'b1;
    logic dg_in, dg_sb, dg_byp, filt_out, cal_busy, cal_done, cal_fail;
    logic [1:0] mode;
    logic [CNT_W-1:0] cal_dly;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    deglitch_ctrl #(
        .CNT_W(CNT_W), .CAL_MAX(CAL_MAX), .MIN_DLY(MIN_DLY), .FILT_LEN(FILT_LEN)
    ) dut (
        .clk(clk), .rstb(rstb), .pad_in(pad_in), .cal_start(cal_start), .byp_req(byp_req),
        .dg_out(dg_out), .dg_dout(dg_dout), .dg_in(dg_in), .dg_sb(dg_sb), .dg_byp(dg_byp),
        .filt_out(filt_out), .mode(mode), .cal_busy(cal_busy), .cal_done(cal_done),
        .cal_fail(cal_fail), .cal_dly(cal_dly), .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // macro model: DOUT is IN delayed dly_sel whole cycles, optionally stuck high
    int dly_sel = 10;
    bit dout_stuck = 1'b0;
    logic [63:0] in_sr = '1;
    always @(negedge clk) begin
        in_sr = {in_sr[62:0], dg_in};
        dg_dout = dout_stuck ? 1'b1 : in_sr[dly_sel];
    end

    // scoreboard: dg_out samples travel 3 cycles to filt_out; digital mode needs FILT_LEN equal samples
    logic [0:0] exp_q[$];
    logic [0:0] win_q[$];
    int   chk_mode = 0;
    logic exp_filt = 1'b1;
    logic filt_min = 1'b1;
    logic smp;
    bit   all_eq;
    always @(negedge clk) begin
        if (!rstb) begin
            exp_q.delete();
        end else begin
            exp_q.push_back(dg_out);
            if (exp_q.size() > 3) begin
                smp = exp_q.pop_front();
                win_q.push_back(smp);
                if (win_q.size() > FILT_LEN) void'(win_q.pop_front());
                if (chk_mode == 1) begin
                    exp_filt = smp;
                end else if (chk_mode == 2 && win_q.size() == FILT_LEN) begin
                    all_eq = 1'b1;
                    foreach (win_q[i]) if (win_q[i] != smp) all_eq = 1'b0;
                    if (all_eq) exp_filt = smp;
                end
                if (chk_mode != 0) check_val("filt_out", filt_out, exp_filt);
            end
        end
        if (!filt_out) filt_min = 1'b0;
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold_out(input logic v, input int n);
        dg_out = v;
        tick(n);
    endtask

    task automatic pulse_cal();
        cal_start = 1'b1;
        tick(1);
        cal_start = 1'b0;
    endtask

    task automatic rand_out(input int n, input bit runs);
        for (int i = 0; i < n; i++) begin
            if (runs) hold_out(($urandom_range(0, 3) == 0) ? ~dg_out : dg_out, 1);
            else hold_out(1'($urandom_range(0, 1)), 1);
        end
    endtask

    // waits for calibration to end; optionally pokes cal_start once while busy
    task automatic wait_idle(input int budget, input int poke_at, output int busy_cycles);
        busy_cycles = 0;
        while (cal_busy && busy_cycles < budget) begin
            cal_start = (busy_cycles == poke_at);
            tick(1);
            busy_cycles++;
        end
        cal_start = 1'b0;
        check_val("cal_timeout", cal_busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset with DG_OUT low
        rstb = 1'b0;
        dg_out = 1'b0;
        tick(3);
        check_val("rst_filt", filt_out, 1'b1);
        check_val("rst_mode", mode, 2'd1);
        check_val("rst_sb", dg_sb, 1'b1);
        check_val("rst_byp", dg_byp, 1'b1);
        check_val("rst_busy", cal_busy, 1'b0);
        check_val("rst_done", cal_done, 1'b0);
        check_val("rst_fail", cal_fail, 1'b0);
        check_val("rst_dly", cal_dly, 0);
        rstb = 1'b1;
        pad_in = 1'b0;
        #1 check_val("idle_dg_in_lo", dg_in, 1'b0);
        pad_in = 1'b1;
        #1 check_val("idle_dg_in_hi", dg_in, 1'b1);

        // 10-cycle chain: analog mode
        hold_out(1'b1, 12);
        dly_sel = 10;
        pulse_cal();
        wait_idle(400, -1, n);
        check_val("cal10_done", cal_done, 1'b1);
        check_val("cal10_fail", cal_fail, 1'b0);
        check_val("cal10_dly", cal_dly, 10);
        check_val("cal10_mode", mode, 2'd0);
        tick(1);
        check_val("cal10_byp", dg_byp, 1'b0);
        hold_out(1'b1, 8);
        chk_mode = 1;
        rand_out(60, 1'b0);
        hold_out(1'b1, 6);
        chk_mode = 0;

        // 3-cycle chain: below MIN_DLY, digital mode and glitch filtering
        dly_sel = 3;
        pulse_cal();
        wait_idle(400, -1, n);
        check_val("cal3_done", cal_done, 1'b1);
        check_val("cal3_dly", cal_dly, 3);
        check_val("cal3_mode", mode, 2'd1);
        hold_out(1'b1, 8);
        exp_filt = 1'b1;
        chk_mode = 2;
        filt_min = 1'b1;
        hold_out(1'b0, 2);
        hold_out(1'b1, 8);
        check_val("glitch2_kept", filt_min, 1'b1);
        filt_min = 1'b1;
        hold_out(1'b0, FILT_LEN);
        hold_out(1'b1, 8);
        check_val("glitch3_passed", filt_min, 1'b0);
        rand_out(80, 1'b1);
        hold_out(1'b1, 8);
        chk_mode = 0;

        // DOUT stuck high: timeout, with an ignored cal_start mid-run
        dout_stuck = 1'b1;
        pulse_cal();
        wait_idle(600, 40, n);
        check_val("fail_flag", cal_fail, 1'b1);
        check_val("fail_done", cal_done, 1'b0);
        check_val("fail_mode", mode, 2'd1);
        check_val("fail_dly_kept", cal_dly, 3);
        check_val("fail_len_ok", (n >= CAL_MAX + 4 && n <= CAL_MAX + 5), 1'b1);
        tick(3);
        check_val("fail_no_restart", cal_busy, 1'b0);
        dout_stuck = 1'b0;

        // bypass request in IDLE
        byp_req = 1'b1;
        tick(2);
        check_val("byp_mode", mode, 2'd2);
        check_val("byp_dg_byp", dg_byp, 1'b1);
        hold_out(1'b1, 8);
        chk_mode = 1;
        rand_out(50, 1'b0);
        hold_out(1'b1, 6);
        chk_mode = 0;
        byp_req = 1'b0;
        tick(2);
        check_val("byp_release_mode", mode, 2'd1);

        // simultaneous CAL_START and BYP_REQ rise
        dly_sel = 10;
        hold_out(1'b1, 14);
        cal_start = 1'b1;
        byp_req = 1'b1;
        tick(1);
        cal_start = 1'b0;
        check_val("simul_busy", cal_busy, 1'b1);
        check_val("simul_mode_hold", mode, 2'd1);
        wait_idle(400, -1, n);
        check_val("simul_done", cal_done, 1'b1);
        check_val("simul_dly", cal_dly, 10);
        check_val("simul_mode", mode, 2'd2);
        check_val("simul_dg_byp", dg_byp, 1'b1);

        // reset during CAL_PULSE
        byp_req = 1'b0;
        dly_sel = 20;
        hold_out(1'b1, 25);
        pulse_cal();
        n = 0;
        while (dbg_state != ST_PULSE && n < 50) begin
            tick(1);
            n++;
        end
        check_val("reach_pulse", dbg_state, ST_PULSE);
        tick(3);
        rstb = 1'b0;
        pad_in = 1'b0;
        tick(1);
        check_val("midrst_state", dbg_state, ST_IDLE);
        check_val("midrst_busy", cal_busy, 1'b0);
        check_val("midrst_done", cal_done, 1'b0);
        check_val("midrst_fail", cal_fail, 1'b0);
        check_val("midrst_dly", cal_dly, 0);
        check_val("midrst_mode", mode, 2'd1);
        check_val("midrst_dg_in", dg_in, 1'b0);
        rstb = 1'b1;
        pad_in = 1'b1;
        #1 check_val("postrst_dg_in", dg_in, 1'b1);
        tick(5);
        check_val("postrst_idle", cal_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
